// File: rtl/sipo_rx.sv
// LSB-first serial-to-parallel receiver with a one-entry valid/ready output buffer,
// mid-word timeout abort and sticky overrun. Define SIPO_PARITY_EN to require a trailing even-parity bit.
module sipo_rx #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             serial_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun,
  output logic             parity_err
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned GAP_W = $clog2(TIMEOUT + 2);
`ifdef SIPO_PARITY_EN
  // Whole word must be held while the parity bit is awaited.
  localparam int unsigned SREG_W = WIDTH;
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2
  } state_t;
`else
  // The final bit joins the word straight from serial_in, so one bit less is stored.
  localparam int unsigned SREG_W = WIDTH - 1;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1
  } state_t;
`endif

  state_t              state_q;
  logic [SREG_W-1:0]   sreg_q;
  logic [CNT_W-1:0]    count_q;
  logic [GAP_W-1:0]    gap_q;
  logic [WIDTH-1:0]    data_out_q;
  logic                data_valid_q;
  logic                busy_q;
  logic                frame_err_q;
  logic                overrun_q;
  logic                parity_err_q;

  logic [SREG_W-1:0]   sreg_d;
  logic                last_bit_c;
  logic                gap_hit_c;
  logic                deliver_c;
  logic [WIDTH-1:0]    word_c;

  assign sreg_d     = {serial_in, sreg_q[SREG_W-1:1]};
  assign last_bit_c = (count_q == CNT_W'(WIDTH - 1));
  assign gap_hit_c  = (TIMEOUT != 0) && (gap_q == GAP_W'(TIMEOUT - 1));

`ifdef SIPO_PARITY_EN
  assign deliver_c  = (state_q == S_PARITY) && serial_valid && (serial_in == ^sreg_q);
  assign word_c     = sreg_q;
`else
  assign deliver_c  = (state_q == S_SHIFT) && serial_valid && last_bit_c;
  assign word_c     = {serial_in, sreg_q};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sreg_q       <= '0;
      count_q      <= '0;
      gap_q        <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (serial_valid) begin
            sreg_q  <= sreg_d;
            count_q <= CNT_W'(1);
            gap_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (serial_valid) begin
            sreg_q <= sreg_d;
            gap_q  <= '0;
            if (last_bit_c) begin
              count_q <= '0;
`ifdef SIPO_PARITY_EN
              state_q <= S_PARITY;
`else
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
`endif
            end else begin
              count_q <= count_q + CNT_W'(1);
            end
          end else if (gap_hit_c) begin
            count_q     <= '0;
            gap_q       <= '0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b1;
            state_q     <= S_IDLE;
          end else if (TIMEOUT != 0) begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
`ifdef SIPO_PARITY_EN
        S_PARITY: begin
          if (serial_valid) begin
            gap_q        <= '0;
            busy_q       <= 1'b0;
            parity_err_q <= (serial_in != ^sreg_q);
            state_q      <= S_IDLE;
          end else if (gap_hit_c) begin
            gap_q       <= '0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b1;
            state_q     <= S_IDLE;
          end else if (TIMEOUT != 0) begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
`endif
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase

      // Output buffer: a same-edge transfer frees the slot for an arriving word.
      if (data_valid_q && data_ready) begin
        data_valid_q <= 1'b0;
      end
      if (deliver_c) begin
        if (!data_valid_q || data_ready) begin
          data_out_q   <= word_c;
          data_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
`ifdef SIPO_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_rx.sv
// Bench for sipo_rx: word-level reference model checked every cycle plus directed literal checks.
// Honours SIPO_PARITY_EN the same way the design does.
module tb_sipo_rx;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned TIMEOUT = 4;

  logic             clk;
  logic             rst;
  logic             serial_in;
  logic             serial_valid;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             data_ready;
  logic             busy;
  logic             frame_err;
  logic             overrun;
  logic             parity_err;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  sipo_rx #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .serial_valid (serial_valid),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .busy         (busy),
    .frame_err    (frame_err),
    .overrun      (overrun),
    .parity_err   (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bits placed by index into an accumulator, word-level buffer rules.
  int          m_n     = 0;
  int          m_gap   = 0;
  bit          m_par   = 1'b0;
  logic [15:0] m_acc   = '0;
  logic [15:0] e_data  = '0;
  bit          e_valid = 1'b0;
  bit          e_busy  = 1'b0;
  bit          e_ferr  = 1'b0;
  bit          e_ovr   = 1'b0;
  bit          e_perr  = 1'b0;

  always @(posedge clk) begin
    bit          done;
    logic [15:0] w;
    done   = 1'b0;
    w      = '0;
    e_ferr = 1'b0;
    e_perr = 1'b0;
    if (rst) begin
      m_n = 0; m_gap = 0; m_par = 1'b0; m_acc = '0;
      e_data = '0; e_valid = 1'b0; e_busy = 1'b0; e_ovr = 1'b0;
    end else begin
      if (serial_valid) begin
        m_gap = 0;
        if (m_par) begin
          m_par = 1'b0;
          if (serial_in == ^m_acc) begin done = 1'b1; w = m_acc; end
          else e_perr = 1'b1;
        end else begin
          m_acc[m_n] = serial_in;
          m_n++;
          if (m_n == WIDTH) begin
            m_n = 0;
`ifdef SIPO_PARITY_EN
            m_par = 1'b1;
`else
            done = 1'b1;
            w    = m_acc;
`endif
          end
        end
      end else if (m_n > 0 || m_par) begin
        m_gap++;
        if (TIMEOUT != 0 && m_gap == TIMEOUT) begin
          m_n = 0; m_par = 1'b0; m_gap = 0; e_ferr = 1'b1;
        end
      end
      if (done) begin
        if (!e_valid || data_ready) begin e_data = w; e_valid = 1'b1; end
        else e_ovr = 1'b1;
      end else if (e_valid && data_ready) begin
        e_valid = 1'b0;
      end
      e_busy = (m_n > 0) || m_par;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_data_valid", 32'(data_valid), 32'(e_valid));
      chk("m_data_out",   32'(data_out),   32'(e_data));
      chk("m_busy",       32'(busy),       32'(e_busy));
      chk("m_frame_err",  32'(frame_err),  32'(e_ferr));
      chk("m_overrun",    32'(overrun),    32'(e_ovr));
      chk("m_parity_err", 32'(parity_err), 32'(e_perr));
    end
  end

  task automatic cyc(input logic sv, input logic si, input logic rdy);
    @(negedge clk);
    serial_valid = sv;
    serial_in    = si;
    data_ready   = rdy;
  endtask

  task automatic rst_cycle();
    @(negedge clk);
    rst          = 1'b1;
    serial_valid = 1'b0;
    @(negedge clk);
    rst          = 1'b0;
  endtask

  // rdy_last applies to the final bit of the frame (parity bit when enabled).
  task automatic send_word(input logic [15:0] w, input logic rdy, input logic rdy_last);
`ifdef SIPO_PARITY_EN
    for (int i = 0; i < 16; i++) cyc(1'b1, w[i], rdy);
    cyc(1'b1, ^w, rdy_last);
`else
    for (int i = 0; i < 15; i++) cyc(1'b1, w[i], rdy);
    cyc(1'b1, w[15], rdy_last);
`endif
  endtask

  initial begin
    logic [15:0] pat;
    rst = 1'b1; serial_valid = 1'b0; serial_in = 1'b0; data_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_data_valid", 32'(data_valid), 32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_data_out",   32'(data_out),   32'd0);
    chk("rst_overrun",    32'(overrun),    32'd0);

    // Single word with the consumer always ready.
    pat = 16'hA5C3;
    cyc(1'b1, pat[0], 1'b1);
    cyc(1'b1, pat[1], 1'b1); #1;
    chk("t1_busy_bit2", 32'(busy), 32'd1);
    for (int i = 2; i < 16; i++) cyc(1'b1, pat[i], 1'b1);
`ifdef SIPO_PARITY_EN
    cyc(1'b1, ^pat, 1'b1);
`endif
    cyc(1'b0, 1'b0, 1'b1); #1;
    chk("t1_data_out",   32'(data_out),   32'hA5C3);
    chk("t1_data_valid", 32'(data_valid), 32'd1);
    chk("t1_busy_after", 32'(busy),       32'd0);
    cyc(1'b0, 1'b0, 1'b1); #1;
    chk("t1_valid_drop", 32'(data_valid), 32'd0);

    // Buffer full, second word dropped.
    send_word(16'h1234, 1'b0, 1'b0);
    send_word(16'hFFFF, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0); #1;
    chk("t2_data_out", 32'(data_out),   32'h1234);
    chk("t2_valid",    32'(data_valid), 32'd1);
    chk("t2_overrun",  32'(overrun),    32'd1);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0); #1;
    chk("t2_valid_after_xfer", 32'(data_valid), 32'd0);
    chk("t2_overrun_sticky",   32'(overrun),    32'd1);
    chk("t2_data_hold",        32'(data_out),   32'h1234);

    // Transfer on the completion edge frees the slot.
    rst_cycle();
    send_word(16'h1234, 1'b0, 1'b0);
    send_word(16'hFFFF, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0); #1;
    chk("t3_data_out", 32'(data_out),   32'hFFFF);
    chk("t3_valid",    32'(data_valid), 32'd1);
    chk("t3_overrun",  32'(overrun),    32'd0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);

    // Mid-word stall hits the timeout.
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'(i % 2), 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1); #1;
    chk("t4_ferr_gap3", 32'(frame_err), 32'd0);
    chk("t4_busy_gap3", 32'(busy),      32'd1);
    cyc(1'b0, 1'b0, 1'b1); #1;
    chk("t4_ferr_gap4", 32'(frame_err),  32'd1);
    chk("t4_busy_gap4", 32'(busy),       32'd0);
    chk("t4_no_valid",  32'(data_valid), 32'd0);
    cyc(1'b0, 1'b0, 1'b1); #1;
    chk("t4_ferr_pulse", 32'(frame_err), 32'd0);
    send_word(16'h00FF, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1); #1;
    chk("t4_data_out", 32'(data_out), 32'h00FF);
    cyc(1'b0, 1'b0, 1'b1);

    // Reset mid-word with a word buffered.
    rst_cycle();
    send_word(16'h1234, 1'b0, 1'b0);
    pat = 16'hBEEF;
    for (int i = 0; i < 10; i++) cyc(1'b1, pat[i], 1'b0);
    rst_cycle(); #1;
    chk("t5_rst_valid",   32'(data_valid), 32'd0);
    chk("t5_rst_busy",    32'(busy),       32'd0);
    chk("t5_rst_data",    32'(data_out),   32'd0);
    chk("t5_rst_overrun", 32'(overrun),    32'd0);
    send_word(16'h8001, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1); #1;
    chk("t5_data_out", 32'(data_out),   32'h8001);
    chk("t5_valid",    32'(data_valid), 32'd1);
    cyc(1'b0, 1'b0, 1'b1);

`ifdef SIPO_PARITY_EN
    // Parity match then mismatch on 0x0003 (even parity bit is 0).
    pat = 16'h0003;
    for (int i = 0; i < 16; i++) cyc(1'b1, pat[i], 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1); #1;
    chk("t6_par_ok_valid", 32'(data_valid), 32'd1);
    chk("t6_par_ok_data",  32'(data_out),   32'h0003);
    chk("t6_par_ok_perr",  32'(parity_err), 32'd0);
    for (int i = 0; i < 16; i++) cyc(1'b1, pat[i], 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1); #1;
    chk("t6_par_bad_perr",  32'(parity_err), 32'd1);
    chk("t6_par_bad_valid", 32'(data_valid), 32'd0);
    cyc(1'b0, 1'b0, 1'b1); #1;
    chk("t6_perr_pulse", 32'(parity_err), 32'd0);
`else
    cyc(1'b0, 1'b0, 1'b1); #1;
    chk("t6_perr_tied", 32'(parity_err), 32'd0);
`endif

    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
